ttl9316_chain: RTL



---
 rtl/ttl9316_chain.sv | 91 +++++++++
 1 files changed

// File: rtl/ttl9316_chain.sv
// Cascaded 9316 synchronous 4-bit presettable binary counters.
// The TTL count clock is oversampled on clk; its rising edges act as count enables.
module ttl9316_chain #(
    parameter int STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ttl_clk,
    input  logic                  clr_n,
    input  logic                  load_n,
    input  logic                  enp,
    input  logic                  ent,
    input  logic [4*STAGES-1:0]   d,
    output logic [4*STAGES-1:0]   q,
    output logic [STAGES-1:0]     rco,
    output logic                  tc
);

    logic                ttl_clk_r;
    logic                ttl_rise_s;
    logic [4*STAGES-1:0] q_r;
    logic [4*STAGES-1:0] q_next_s;
    logic [STAGES-1:0]   ent_s;
    logic [STAGES-1:0]   rco_s;

    function automatic logic nibble_full(input logic [3:0] nib);
        return (nib == 4'hF);
    endfunction

    // TTL clock history; resets high so a pin held high through reset is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ttl_clk_r <= 1'b1;
        end else begin
            ttl_clk_r <= ttl_clk;
        end
    end

    assign ttl_rise_s = ttl_clk & ~ttl_clk_r;

    // Carry chain from pre-edge q, so every stage advances on the same clk edge.
    always_comb begin
        logic carry_v;
        ent_s   = {STAGES{1'b0}};
        rco_s   = {STAGES{1'b0}};
        carry_v = ent;
        for (int i = 0; i < STAGES; i++) begin
            ent_s[i] = carry_v;
            rco_s[i] = carry_v & nibble_full(q_r[4*i +: 4]);
            carry_v  = rco_s[i];
        end
    end

    // Next counter value: clear beats load beats count.
    always_comb begin
        q_next_s = q_r;
        if (!clr_n) begin
            q_next_s = {(4*STAGES){1'b0}};
        end else if (!load_n) begin
            if (ttl_rise_s) begin
                q_next_s = d;
            end else begin
                q_next_s = q_r;
            end
        end else if (ttl_rise_s && enp) begin
            for (int i = 0; i < STAGES; i++) begin
                if (ent_s[i]) begin
                    q_next_s[4*i +: 4] = q_r[4*i +: 4] + 4'd1;
                end else begin
                    q_next_s[4*i +: 4] = q_r[4*i +: 4];
                end
            end
        end else begin
            q_next_s = q_r;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= {(4*STAGES){1'b0}};
        end else begin
            q_r <= q_next_s;
        end
    end

    assign q   = q_r;
    assign rco = rco_s;
    assign tc  = rco_s[STAGES-1];

endmodule
